// File: rtl/sti_rx_if.sv
// sti_rx_if: STI serial input, frame configuration and recovered-word outputs of the receiver.
interface sti_rx_if;
  logic        si_data;
  logic        si_valid;
  logic        cfg_msb;
  logic        cfg_low;
  logic [1:0]  cfg_length;
  logic        cfg_fill;
  logic [15:0] po_data;
  logic        po_valid;
  logic        po_err;
  logic        busy;
  modport master (output si_data, si_valid, cfg_msb, cfg_low, cfg_length, cfg_fill,
                  input po_data, po_valid, po_err, busy);
  modport slave  (input si_data, si_valid, cfg_msb, cfg_low, cfg_length, cfg_fill,
                  output po_data, po_valid, po_err, busy);
endinterface

// File: rtl/sti_rx.sv
// sti_rx: STI serial-to-parallel receiver that rebuilds the 16-bit word from 8/16/24/32-bit frames.
// Define STI_RX_PAD_CHECK_EN to reject 24/32-bit frames whose pad bits are not all zero.
module sti_rx #(
  parameter int CNT_W = 6
) (
  input logic   clk,
  input logic   reset,
  sti_rx_if.slave bus
);
  typedef enum logic {IDLE, RECV} state_t;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      w_q;
  logic             msb_q, low_q, fill_q;
  logic [1:0]       len_q;
  logic [15:0]      data_q;
  logic             valid_q, err_q, busy_q;
  logic [CNT_W-1:0] n_cur, n_new, pos_cur, pos_new;
  logic [15:0]      word;
  logic             bad, done, start;
  assign n_cur   = CNT_W'({len_q, 3'b000}) + CNT_W'(8);
  assign n_new   = CNT_W'({bus.cfg_length, 3'b000}) + CNT_W'(8);
  assign pos_cur = msb_q ? n_cur - CNT_W'(1) - cnt_q : cnt_q;
  assign pos_new = bus.cfg_msb ? n_new - CNT_W'(1) : '0;
  assign done    = state_q == RECV && cnt_q == n_cur;
  // a bit arriving right after the last bit of a frame opens the next frame
  assign start   = bus.si_valid && (state_q == IDLE || done);
  assign word = len_q == 2'd0 ? (low_q ? {w_q[7:0], 8'h00} : {8'h00, w_q[7:0]}) :
                len_q == 2'd1 ? w_q[15:0] :
                len_q == 2'd2 ? (fill_q ? w_q[23:8] : w_q[15:0]) :
                                (fill_q ? w_q[31:16] : w_q[15:0]);
`ifdef STI_RX_PAD_CHECK_EN
  assign bad = len_q == 2'd2 ? (fill_q ? |w_q[7:0] : |w_q[23:16]) :
               len_q == 2'd3 ? (fill_q ? |w_q[15:0] : |w_q[31:16]) : 1'b0;
`else
  assign bad = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      msb_q   <= 1'b0;
      low_q   <= 1'b0;
      fill_q  <= 1'b0;
      len_q   <= 2'd0;
      data_q  <= 16'h0000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= done && !bad;
      err_q   <= (done && bad) || (state_q == RECV && !done && !bus.si_valid);
      if (done && !bad) data_q <= word;
      if (start) begin
        msb_q   <= bus.cfg_msb;
        low_q   <= bus.cfg_low;
        len_q   <= bus.cfg_length;
        fill_q  <= bus.cfg_fill;
        w_q     <= 32'(bus.si_data) << pos_new;
        cnt_q   <= CNT_W'(1);
        state_q <= RECV;
        busy_q  <= 1'b1;
      end else if (state_q == RECV && bus.si_valid && !done) begin
        w_q   <= w_q | (32'(bus.si_data) << pos_cur);
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (state_q == RECV) begin
        cnt_q   <= '0;
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end
    end
  end
  assign bus.po_data  = data_q;
  assign bus.po_valid = valid_q;
  assign bus.po_err   = err_q;
  assign bus.busy     = busy_q;
endmodule
